// File: rtl/rs_gen2_if.sv
// rs_gen2_if -- issue, CDB and dispatch bundle for the rs_gen2 reservation station.
// The master side is the front end/bench, and the slave side is the station.
interface rs_gen2_if #(
   parameter int RS_DEPTH = 8,
   parameter int TAG_W    = 4,
   parameter int XLEN     = 32,
   parameter int OP_W     = 6,
   parameter int NCDB     = 2
);
   localparam int CW = $clog2(RS_DEPTH) + 1;

   logic                   iss_valid;
   logic [OP_W-1:0]        iss_op;
   logic [TAG_W-1:0]       iss_tag;
   logic [XLEN-1:0]        iss_v1;
   logic [XLEN-1:0]        iss_v2;
   logic [TAG_W-1:0]       iss_q1;
   logic [TAG_W-1:0]       iss_q2;
   logic                   iss_rdy1;
   logic                   iss_rdy2;
   logic                   full;
   logic [CW-1:0]          count;
   logic [NCDB-1:0]        cdb_valid;
   logic [NCDB*TAG_W-1:0]  cdb_tag;
   logic [NCDB*XLEN-1:0]   cdb_val;
   logic                   dsp_valid;
   logic                   dsp_ready;
   logic [OP_W-1:0]        dsp_op;
   logic [TAG_W-1:0]       dsp_tag;
   logic [XLEN-1:0]        dsp_v1;
   logic [XLEN-1:0]        dsp_v2;

   modport master (
      output iss_valid, iss_op, iss_tag, iss_v1, iss_v2, iss_q1, iss_q2, iss_rdy1, iss_rdy2,
      output cdb_valid, cdb_tag, cdb_val, dsp_ready,
      input  full, count, dsp_valid, dsp_op, dsp_tag, dsp_v1, dsp_v2
   );

   modport slave (
      input  iss_valid, iss_op, iss_tag, iss_v1, iss_v2, iss_q1, iss_q2, iss_rdy1, iss_rdy2,
      input  cdb_valid, cdb_tag, cdb_val, dsp_ready,
      output full, count, dsp_valid, dsp_op, dsp_tag, dsp_v1, dsp_v2
   );
endinterface

// File: rtl/rs_gen2.sv
// rs_gen2 -- out-of-order reservation station with CDB wakeup, oldest-ready
// selection and a single registered dispatch slot.
// Optional feature: define RS_WAKEUP_BYPASS_EN to let an entry be selected in
// the same cycle its last operand arrives on the CDB (the value is forwarded
// straight into the dispatch register). When the macro is undefined, such an entry
// becomes selectable one cycle later.
module rs_gen2 #(
   parameter int RS_DEPTH = 8,
   parameter int TAG_W    = 4,
   parameter int XLEN     = 32,
   parameter int OP_W     = 6,
   parameter int NCDB     = 2
) (
   input  logic     clk,
   input  logic     rst_in,
   input  logic     rdy_in,
   input  logic     flush,
   rs_gen2_if.slave bus
);
   localparam int IW = $clog2(RS_DEPTH);
   localparam int CW = $clog2(RS_DEPTH) + 1;

   // Entry state
   logic [RS_DEPTH-1:0] vld_q, vld_d;
   logic [RS_DEPTH-1:0] rdy1_q, rdy1_d;
   logic [RS_DEPTH-1:0] rdy2_q, rdy2_d;
   logic [OP_W-1:0]     op_q  [RS_DEPTH];
   logic [OP_W-1:0]     op_d  [RS_DEPTH];
   logic [TAG_W-1:0]    tag_q [RS_DEPTH];
   logic [TAG_W-1:0]    tag_d [RS_DEPTH];
   logic [TAG_W-1:0]    q1_q  [RS_DEPTH];
   logic [TAG_W-1:0]    q1_d  [RS_DEPTH];
   logic [TAG_W-1:0]    q2_q  [RS_DEPTH];
   logic [TAG_W-1:0]    q2_d  [RS_DEPTH];
   logic [XLEN-1:0]     v1_q  [RS_DEPTH];
   logic [XLEN-1:0]     v1_d  [RS_DEPTH];
   logic [XLEN-1:0]     v2_q  [RS_DEPTH];
   logic [XLEN-1:0]     v2_d  [RS_DEPTH];
   // older_q[i][j] = 1 means entry j was issued before entry i
   logic [RS_DEPTH-1:0] older_q [RS_DEPTH];
   logic [RS_DEPTH-1:0] older_d [RS_DEPTH];
   logic [CW-1:0]       count_q, count_d;

   // Dispatch register
   logic                dsp_valid_q, dsp_valid_d;
   logic [OP_W-1:0]     dsp_op_q, dsp_op_d;
   logic [TAG_W-1:0]    dsp_tag_q, dsp_tag_d;
   logic [XLEN-1:0]     dsp_v1_q, dsp_v1_d;
   logic [XLEN-1:0]     dsp_v2_q, dsp_v2_d;

   // Combinational helpers
   logic [RS_DEPTH-1:0] hit1, hit2;
   logic [XLEN-1:0]     wval1 [RS_DEPTH];
   logic [XLEN-1:0]     wval2 [RS_DEPTH];
   logic [XLEN:0]       lk1, lk2;
   logic [XLEN:0]       ilk1, ilk2;
   logic [RS_DEPTH-1:0] cand;
   logic                sel_any;
   logic [IW-1:0]       sel_idx;
   logic [IW-1:0]       free_idx;
   logic                full_w;
   logic                iss_acc;
   logic                load;

   // Search the CDB channels for tag q; the lowest matching channel wins.
   // Returns {hit, value}.
   function automatic logic [XLEN:0] cdb_lookup(
      input logic [TAG_W-1:0]      q,
      input logic [NCDB-1:0]       cv,
      input logic [NCDB*TAG_W-1:0] ct,
      input logic [NCDB*XLEN-1:0]  cval
   );
      logic [XLEN:0] r;
      r = '0;
      for (int c = NCDB - 1; c >= 0; c--) begin
         if (cv[c] && (ct[c*TAG_W +: TAG_W] == q)) begin
            r = {1'b1, cval[c*XLEN +: XLEN]};
         end
      end
      return r;
   endfunction

   assign full_w        = (count_q == CW'(RS_DEPTH));
   assign bus.full      = full_w;
   assign bus.count     = count_q;
   assign bus.dsp_valid = dsp_valid_q;
   assign bus.dsp_op    = dsp_op_q;
   assign bus.dsp_tag   = dsp_tag_q;
   assign bus.dsp_v1    = dsp_v1_q;
   assign bus.dsp_v2    = dsp_v2_q;

   // CDB match for every valid entry with a pending operand
   always_comb begin
      lk1 = '0;
      lk2 = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         lk1      = cdb_lookup(q1_q[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
         lk2      = cdb_lookup(q2_q[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
         hit1[i]  = lk1[XLEN] & vld_q[i] & ~rdy1_q[i];
         hit2[i]  = lk2[XLEN] & vld_q[i] & ~rdy2_q[i];
         wval1[i] = lk1[XLEN-1:0];
         wval2[i] = lk2[XLEN-1:0];
      end
   end

   // Oldest-ready selection and lowest free slot
   always_comb begin
      for (int i = 0; i < RS_DEPTH; i++) begin
`ifdef RS_WAKEUP_BYPASS_EN
         cand[i] = vld_q[i] & (rdy1_q[i] | hit1[i]) & (rdy2_q[i] | hit2[i]);
`else
         cand[i] = vld_q[i] & rdy1_q[i] & rdy2_q[i];
`endif
      end
      sel_any = 1'b0;
      sel_idx = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         if (cand[i] && ((cand & older_q[i]) == '0)) begin
            sel_any = 1'b1;
            sel_idx = IW'(i);
         end
      end
      free_idx = '0;
      for (int i = RS_DEPTH - 1; i >= 0; i--) begin
         if (!vld_q[i]) free_idx = IW'(i);
      end
   end

   // Next-state: wakeup, dispatch load, issue write, flush and freeze
   always_comb begin
      vld_d       = vld_q;
      rdy1_d      = rdy1_q;
      rdy2_d      = rdy2_q;
      op_d        = op_q;
      tag_d       = tag_q;
      q1_d        = q1_q;
      q2_d        = q2_q;
      v1_d        = v1_q;
      v2_d        = v2_q;
      older_d     = older_q;
      count_d     = count_q;
      dsp_valid_d = dsp_valid_q;
      dsp_op_d    = dsp_op_q;
      dsp_tag_d   = dsp_tag_q;
      dsp_v1_d    = dsp_v1_q;
      dsp_v2_d    = dsp_v2_q;

      iss_acc = rdy_in & ~flush & bus.iss_valid & ~full_w;
      load    = rdy_in & ~flush & sel_any & (~dsp_valid_q | bus.dsp_ready);
      ilk1    = cdb_lookup(bus.iss_q1, bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
      ilk2    = cdb_lookup(bus.iss_q2, bus.cdb_valid, bus.cdb_tag, bus.cdb_val);

      if (rdy_in) begin
         if (flush) begin
            vld_d       = '0;
            count_d     = '0;
            dsp_valid_d = 1'b0;
         end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
               if (hit1[i]) begin
                  rdy1_d[i] = 1'b1;
                  v1_d[i]   = wval1[i];
               end
               if (hit2[i]) begin
                  rdy2_d[i] = 1'b1;
                  v2_d[i]   = wval2[i];
               end
            end

            if (!dsp_valid_q || bus.dsp_ready) begin
               dsp_valid_d = sel_any;
               if (sel_any) begin
                  vld_d[sel_idx] = 1'b0;
                  dsp_op_d       = op_q[sel_idx];
                  dsp_tag_d      = tag_q[sel_idx];
                  dsp_v1_d       = hit1[sel_idx] ? wval1[sel_idx] : v1_q[sel_idx];
                  dsp_v2_d       = hit2[sel_idx] ? wval2[sel_idx] : v2_q[sel_idx];
               end
            end

            if (iss_acc) begin
               vld_d[free_idx]  = 1'b1;
               op_d[free_idx]   = bus.iss_op;
               tag_d[free_idx]  = bus.iss_tag;
               q1_d[free_idx]   = bus.iss_q1;
               q2_d[free_idx]   = bus.iss_q2;
               rdy1_d[free_idx] = bus.iss_rdy1 | ilk1[XLEN];
               rdy2_d[free_idx] = bus.iss_rdy2 | ilk2[XLEN];
               v1_d[free_idx]   = (bus.iss_rdy1 || !ilk1[XLEN]) ? bus.iss_v1 : ilk1[XLEN-1:0];
               v2_d[free_idx]   = (bus.iss_rdy2 || !ilk2[XLEN]) ? bus.iss_v2 : ilk2[XLEN-1:0];
               // The new entry is younger than everything currently resident
               for (int j = 0; j < RS_DEPTH; j++) begin
                  older_d[j][free_idx] = 1'b0;
               end
               older_d[free_idx] = vld_q;
            end

            count_d = count_q + CW'(iss_acc) - CW'(load);
         end
      end
   end

   // Control state and dispatch register, cleared by reset
   always_ff @(posedge clk) begin
      if (!rst_in) begin
         vld_q       <= '0;
         count_q     <= '0;
         dsp_valid_q <= 1'b0;
         dsp_op_q    <= '0;
         dsp_tag_q   <= '0;
         dsp_v1_q    <= '0;
         dsp_v2_q    <= '0;
      end else begin
         vld_q       <= vld_d;
         count_q     <= count_d;
         dsp_valid_q <= dsp_valid_d;
         dsp_op_q    <= dsp_op_d;
         dsp_tag_q   <= dsp_tag_d;
         dsp_v1_q    <= dsp_v1_d;
         dsp_v2_q    <= dsp_v2_d;
      end
   end

   // Entry payload, operand readiness and age matrix (meaningful only while valid)
   always_ff @(posedge clk) begin
      rdy1_q  <= rdy1_d;
      rdy2_q  <= rdy2_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      q1_q    <= q1_d;
      q2_q    <= q2_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      older_q <= older_d;
   end
endmodule

// File: tb/tb_rs_gen2.sv
// tb_rs_gen2 -- directed bench for the rs_gen2 reservation station.
module tb_rs_gen2;
   localparam int RS_DEPTH = 8;
   localparam int TAG_W    = 4;
   localparam int XLEN     = 32;
   localparam int OP_W     = 6;
   localparam int NCDB     = 2;

   logic clk;
   logic rst_in;
   logic rdy_in;
   logic flush;
   int   checks = 0;
   int   errors = 0;

   rs_gen2_if #(.RS_DEPTH(RS_DEPTH), .TAG_W(TAG_W), .XLEN(XLEN), .OP_W(OP_W), .NCDB(NCDB)) bus ();

   rs_gen2 #(.RS_DEPTH(RS_DEPTH), .TAG_W(TAG_W), .XLEN(XLEN), .OP_W(OP_W), .NCDB(NCDB)) dut (
      .clk    (clk),
      .rst_in (rst_in),
      .rdy_in (rdy_in),
      .flush  (flush),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      rdy_in        = 1'b1;
      flush         = 1'b0;
      bus.iss_valid = 1'b0;
      bus.iss_op    = '0;
      bus.iss_tag   = '0;
      bus.iss_v1    = '0;
      bus.iss_v2    = '0;
      bus.iss_q1    = '0;
      bus.iss_q2    = '0;
      bus.iss_rdy1  = 1'b0;
      bus.iss_rdy2  = 1'b0;
      bus.cdb_valid = '0;
      bus.cdb_tag   = '0;
      bus.cdb_val   = '0;
      bus.dsp_ready = 1'b1;
   endtask

   task automatic issue(input logic [5:0] op, input logic [3:0] tag,
                        input logic [31:0] v1, input logic [31:0] v2,
                        input logic [3:0] q1, input logic r1,
                        input logic [3:0] q2, input logic r2);
      bus.iss_valid = 1'b1;
      bus.iss_op    = op;
      bus.iss_tag   = tag;
      bus.iss_v1    = v1;
      bus.iss_v2    = v2;
      bus.iss_q1    = q1;
      bus.iss_q2    = q2;
      bus.iss_rdy1  = r1;
      bus.iss_rdy2  = r2;
   endtask

   initial begin
      // Reset
      idle();
      rst_in = 1'b0;
      tick();
      tick();
      chk("rst_dsp_valid", bus.dsp_valid, 0);
      chk("rst_count", bus.count, 0);
      chk("rst_full", bus.full, 0);
      chk("rst_dsp_tag", bus.dsp_tag, 0);
      chk("rst_dsp_v1", bus.dsp_v1, 0);
      rst_in = 1'b1;

      // Single ready issue: dispatch after the following edge
      issue(6'h13, 4'd3, 32'd5, 32'd7, 4'd0, 1'b1, 4'd0, 1'b1);
      tick();
      chk("basic_count_after_issue", bus.count, 1);
      chk("basic_not_yet_valid", bus.dsp_valid, 0);
      idle();
      tick();
      chk("basic_dsp_valid", bus.dsp_valid, 1);
      chk("basic_dsp_op", bus.dsp_op, 6'h13);
      chk("basic_dsp_tag", bus.dsp_tag, 3);
      chk("basic_dsp_v1", bus.dsp_v1, 5);
      chk("basic_dsp_v2", bus.dsp_v2, 7);
      chk("basic_count_zero", bus.count, 0);
      tick();
      chk("basic_drained", bus.dsp_valid, 0);

      // Waiting entry woken by CDB channel 1; ready younger entry goes first
      issue(6'h01, 4'd1, 32'd0, 32'h22, 4'd9, 1'b0, 4'd0, 1'b1);
      tick();
      chk("wake_count1", bus.count, 1);
      issue(6'h02, 4'd2, 32'h10, 32'h20, 4'd0, 1'b1, 4'd0, 1'b1);
      tick();
      chk("wake_count2", bus.count, 2);
      chk("wake_none_ready", bus.dsp_valid, 0);
      idle();
      tick();
      chk("wake_first_tag", bus.dsp_tag, 2);
      chk("wake_first_v1", bus.dsp_v1, 32'h10);
      chk("wake_first_valid", bus.dsp_valid, 1);
      bus.cdb_valid = 2'b10;
      bus.cdb_tag   = {4'd9, 4'd0};
      bus.cdb_val   = {32'hAA, 32'h0};
      tick();
      idle();
`ifdef RS_WAKEUP_BYPASS_EN
      chk("wake_byp_valid", bus.dsp_valid, 1);
      chk("wake_byp_tag", bus.dsp_tag, 1);
      chk("wake_byp_v1", bus.dsp_v1, 32'hAA);
      chk("wake_byp_v2", bus.dsp_v2, 32'h22);
      chk("wake_byp_count", bus.count, 0);
      tick();
      chk("wake_byp_drained", bus.dsp_valid, 0);
`else
      chk("wake_nobyp_gap", bus.dsp_valid, 0);
      chk("wake_nobyp_count", bus.count, 1);
      tick();
      chk("wake_nobyp_valid", bus.dsp_valid, 1);
      chk("wake_nobyp_tag", bus.dsp_tag, 1);
      chk("wake_nobyp_v1", bus.dsp_v1, 32'hAA);
      chk("wake_nobyp_v2", bus.dsp_v2, 32'h22);
      chk("wake_nobyp_count0", bus.count, 0);
`endif
      tick();
      chk("wake_idle", bus.dsp_valid, 0);

      // Issue-time capture from CDB; two channels match, channel 0 must win
      issue(6'h05, 4'd5, 32'h11, 32'd0, 4'd0, 1'b1, 4'd4, 1'b0);
      bus.cdb_valid = 2'b11;
      bus.cdb_tag   = {4'd4, 4'd4};
      bus.cdb_val   = {32'h66, 32'h55};
      tick();
      idle();
      chk("capt_count", bus.count, 1);
      tick();
      chk("capt_valid", bus.dsp_valid, 1);
      chk("capt_tag", bus.dsp_tag, 5);
      chk("capt_v1", bus.dsp_v1, 32'h11);
      chk("capt_v2", bus.dsp_v2, 32'h55);
      tick();
      chk("capt_drained", bus.dsp_valid, 0);

      // Fill: tag0 parks in the stalled dispatch slot, tags 1..8 fill the station
      issue(6'h00, 4'd0, 32'h0, 32'h0, 4'd0, 1'b1, 4'd0, 1'b1);
      bus.dsp_ready = 1'b0;
      tick();
      chk("fill_count_first", bus.count, 1);
      for (int t = 1; t <= 8; t++) begin
         issue(6'(t), 4'(t), 32'(t * 16), 32'(t), 4'd0, 1'b1, 4'd0, 1'b1);
         tick();
      end
      chk("fill_count8", bus.count, 8);
      chk("fill_full", bus.full, 1);
      chk("fill_dsp_tag0", bus.dsp_tag, 0);
      issue(6'h09, 4'd9, 32'h90, 32'h9, 4'd0, 1'b1, 4'd0, 1'b1);
      tick();
      chk("fill_ninth_ignored", bus.count, 8);
      chk("fill_stall_hold_tag", bus.dsp_tag, 0);
      chk("fill_stall_hold_valid", bus.dsp_valid, 1);
      issue(6'h0A, 4'd10, 32'hA0, 32'hA, 4'd0, 1'b1, 4'd0, 1'b1);
      bus.dsp_ready = 1'b1;
      tick();
      chk("fill_pulse_count", bus.count, 7);
      chk("fill_pulse_full", bus.full, 0);
      chk("fill_oldest_tag", bus.dsp_tag, 1);
      chk("fill_oldest_v1", bus.dsp_v1, 32'h10);
      bus.dsp_ready = 1'b0;
      tick();
      chk("fill_reuse_count", bus.count, 8);
      chk("fill_reuse_full", bus.full, 1);

      // Freeze with rdy_in=0 while every other input is active
      rdy_in        = 1'b0;
      bus.dsp_ready = 1'b1;
      bus.cdb_valid = 2'b01;
      bus.cdb_tag   = {4'd0, 4'd3};
      bus.cdb_val   = {32'h0, 32'h77};
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("frz_count", bus.count, 8);
         chk("frz_valid", bus.dsp_valid, 1);
         chk("frz_tag", bus.dsp_tag, 1);
      end
      chk("frz_op", bus.dsp_op, 1);
      chk("frz_v2", bus.dsp_v2, 1);

      // Flush drops everything, including a same-cycle issue
      idle();
      bus.dsp_ready = 1'b0;
      flush = 1'b1;
      issue(6'h0B, 4'd11, 32'hB0, 32'hB, 4'd0, 1'b1, 4'd0, 1'b1);
      tick();
      chk("flush_count", bus.count, 0);
      chk("flush_valid", bus.dsp_valid, 0);
      chk("flush_full", bus.full, 0);
      idle();
      tick();
      chk("flush_issue_dropped", bus.count, 0);
      chk("flush_still_empty", bus.dsp_valid, 0);

      // Reset during a stalled dispatch
      bus.dsp_ready = 1'b0;
      issue(6'h06, 4'd6, 32'h60, 32'h6, 4'd0, 1'b1, 4'd0, 1'b1);
      tick();
      issue(6'h07, 4'd7, 32'h70, 32'h7, 4'd0, 1'b1, 4'd0, 1'b1);
      tick();
      bus.iss_valid = 1'b0;
      chk("mrst_pre_valid", bus.dsp_valid, 1);
      chk("mrst_pre_tag", bus.dsp_tag, 6);
      chk("mrst_pre_count", bus.count, 1);
      rst_in = 1'b0;
      tick();
      chk("mrst_valid", bus.dsp_valid, 0);
      chk("mrst_op", bus.dsp_op, 0);
      chk("mrst_tag", bus.dsp_tag, 0);
      chk("mrst_v1", bus.dsp_v1, 0);
      chk("mrst_v2", bus.dsp_v2, 0);
      chk("mrst_count", bus.count, 0);
      chk("mrst_full", bus.full, 0);
      rst_in = 1'b1;
      idle();
      tick();
      chk("mrst_entry_discarded", bus.dsp_valid, 0);
      chk("mrst_count_after", bus.count, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
